// File: rtl/decryption_r2_pkg.sv
// Shared definitions for the R2 decryption stage: FSM state encoding and default widths.
package decryption_r2_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_KW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        RED,
        BIT,
        MUL,
        SQR,
        FIN
    } state_t;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: r = (a * b) mod p, scanning b MSB-first, one bit per cycle.
// Requires a < p; an operation takes one issue cycle plus WIDTH bit cycles.
module mod_mul_serial
    import decryption_r2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0] w_p_ext;
    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_red;
    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_next;

    // One extra bit of headroom: acc < p and a < p, so 2*acc and acc+a never overflow.
    always_comb begin
        w_p_ext = {1'b0, p};
        w_dbl   = r_acc << 1;
        w_red   = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
        w_add   = w_red + {1'b0, r_a};
        if (r_b[WIDTH-1]) begin
            w_next = (w_add >= w_p_ext) ? (w_add - w_p_ext) : w_add;
        end else begin
            w_next = w_red;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (go && !busy) begin
            r_acc <= '0;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= CW'(WIDTH);
        end else if (busy) begin
            r_acc <= w_next;
            r_b   <= r_b << 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // done and r are combinational in the last bit cycle so the caller can chain ops back to back.
    assign busy = (r_cnt != '0);
    assign done = (r_cnt == CW'(1));
    assign r    = w_next[WIDTH-1:0];

endmodule

// File: rtl/decryption_r2.sv
// R2 decryption stage: recomputes k = pub_b^priv_x mod p by right-to-left square-and-multiply
// over one shared serial multiplier, then recovers r2 = c1 ^ k[KW-1:0].
module decryption_r2
    import decryption_r2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = DEF_KW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    c1,
    input  logic [WIDTH-1:0] pub_b,
    input  logic [WIDTH-1:0] priv_x,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done_dec,
    output logic             err,
    output logic [KW-1:0]    k_o,
    output logic [KW-1:0]    r2_o
);

    state_t r_state;
    state_t w_next_state;

    logic [KW-1:0]    r_c1;
    logic [WIDTH-1:0] r_pub_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_base;
    logic             r_bad;
    logic             r_done;
    logic             r_err;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_r2;

    logic             w_mul_go;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_b;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_r;

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .go   (w_mul_go),
        .a    (w_mul_a),
        .b    (w_mul_b),
        .p    (r_p),
        .busy (w_mul_busy),
        .done (w_mul_done),
        .r    (w_mul_r)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // BIT doubles as the issue cycle of the following MUL or SQR, so the decision costs no time.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latches are inferred.
        w_next_state = r_state;
        w_mul_go     = 1'b0;
        w_mul_a      = '0;
        w_mul_b      = '0;
        unique case (r_state)
            IDLE: if (start) w_next_state = CHK;
            CHK:  w_next_state = (r_p < WIDTH'(2)) ? FIN : RED;
            RED: begin
                w_mul_go = !w_mul_busy;
                w_mul_a  = WIDTH'(1);
                w_mul_b  = r_pub_b;
                if (w_mul_done) w_next_state = (r_e == '0) ? FIN : BIT;
            end
            BIT: begin
                w_mul_go = 1'b1;
                if (r_e[0]) begin
                    w_mul_a      = r_res;
                    w_mul_b      = r_base;
                    w_next_state = MUL;
                end else begin
                    w_mul_a      = r_base;
                    w_mul_b      = r_base;
                    w_next_state = SQR;
                end
            end
            MUL: if (w_mul_done) w_next_state = (r_e[WIDTH-1:1] == '0) ? FIN : BIT;
            SQR: if (w_mul_done) w_next_state = BIT;
            FIN: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // After a MUL, bit 0 of e is cleared rather than shifted; BIT then sees 0 and shifts before SQR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c1    <= '0;
            r_pub_b <= '0;
            r_p     <= '0;
            r_e     <= '0;
            r_res   <= '0;
            r_base  <= '0;
            r_bad   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_k     <= '0;
            r_r2    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: if (start) begin
                    r_c1    <= c1;
                    r_pub_b <= pub_b;
                    r_p     <= p;
                    r_e     <= priv_x;
                    r_bad   <= 1'b0;
                    r_err   <= 1'b0;
                end
                CHK: if (r_p < WIDTH'(2)) begin
                    r_bad <= 1'b1;
                    r_res <= '0;
                end
                RED: if (w_mul_done) begin
                    r_base <= w_mul_r;
                    r_res  <= WIDTH'(1);
                end
                BIT: if (!r_e[0]) r_e <= r_e >> 1;
                MUL: if (w_mul_done) begin
                    r_res  <= w_mul_r;
                    r_e[0] <= 1'b0;
                end
                SQR: if (w_mul_done) r_base <= w_mul_r;
                FIN: begin
                    r_done <= 1'b1;
                    r_err  <= r_bad;
                    r_k    <= r_res[KW-1:0];
                    r_r2   <= r_c1 ^ r_res[KW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done_dec = r_done;
    assign err      = r_err;
    assign k_o      = r_k;
    assign r2_o     = r_r2;

endmodule

// File: tb/tb_decryption_r2.sv
// Self-checking bench for decryption_r2: directed vectors, randomized runs against a
// modular-exponentiation reference, start-while-busy and reset-abort scenarios.
module tb_decryption_r2;

    localparam int WIDTH  = 32;
    localparam int KW     = 4;
    localparam int BUDGET = 2500;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [KW-1:0]    c1;
    logic [WIDTH-1:0] pub_b;
    logic [WIDTH-1:0] priv_x;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done_dec;
    logic             err;
    logic [KW-1:0]    k_o;
    logic [KW-1:0]    r2_o;

    int n_checks = 0;
    int n_fail   = 0;

    decryption_r2 #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .c1       (c1),
        .pub_b    (pub_b),
        .priv_x   (priv_x),
        .p        (p),
        .busy     (busy),
        .done_dec (done_dec),
        .err      (err),
        .k_o      (k_o),
        .r2_o     (r2_o)
    );

    always #5 clk = ~clk;

    // Left-to-right exponentiation with native 64-bit products.
    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] x,
                                            input logic [31:0] m);
        logic [63:0] acc;
        logic [63:0] bb;
        logic [63:0] mm;
        mm  = {32'd0, m};
        bb  = {32'd0, b} % mm;
        acc = 64'd1;
        for (int i = 31; i >= 0; i--) begin
            acc = (acc * acc) % mm;
            if (x[i]) acc = (acc * bb) % mm;
        end
        return acc[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] m);
        int bl;
        int ops;
        if (m < 32'd2) return 2;
        bl = 0;
        for (int i = 0; i < 32; i++) if (x[i]) bl = i + 1;
        ops = 1 + $countones(x) + ((bl > 0) ? bl - 1 : 0);
        return ops * (WIDTH + 1) + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one request, scrambles inputs afterwards, waits for done_dec within BUDGET cycles.
    task automatic run_op(input logic [3:0] c, input logic [31:0] b, input logic [31:0] x,
                          input logic [31:0] m, output int lat, output logic busy_ok,
                          output logic err0);
        c1 = c; pub_b = b; priv_x = x; p = m; start = 1'b1;
        tick();
        start   = 1'b0;
        busy_ok = busy;
        err0    = err;
        c1 = 4'($urandom); pub_b = $urandom; priv_x = $urandom; p = $urandom;
        lat = -1;
        for (int n = 1; n <= BUDGET; n++) begin
            tick();
            if (done_dec) begin
                if (busy) busy_ok = 1'b0;
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; c1 = '0; pub_b = '0; priv_x = '0; p = '0;
        repeat (3) tick();
        n_checks++;
        if ({busy, done_dec, err, k_o, r2_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got busy=%b done=%b err=%b k=%h r2=%h, expected all 0",
                     busy, done_dec, err, k_o, r2_o);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: got busy=%b done=%b, expected 0 0", busy, done_dec);
        end
    endtask

    task automatic test_known();
        logic [3:0]  t_c1  [5];
        logic [31:0] t_b   [5];
        logic [31:0] t_x   [5];
        logic [31:0] t_p   [5];
        logic [3:0]  t_k   [5];
        logic [3:0]  t_r2  [5];
        logic        t_err [5];
        int          t_lat [5];
        int          lat;
        logic        bok;
        logic        e0;
        t_c1  = '{4'h5, 4'h0, 4'h3, 4'hF, 4'h9};
        t_b   = '{32'd8, 32'd100, 32'd5, 32'd2, 32'd77};
        t_x   = '{32'd6, 32'd1, 32'd0, 32'd32, 32'd12345};
        t_p   = '{32'd23, 32'd23, 32'd23, 32'hFFFF_FFFB, 32'd1};
        t_k   = '{4'hD, 4'h8, 4'h1, 4'h5, 4'h0};
        t_r2  = '{4'h8, 4'h8, 4'h2, 4'hA, 4'h9};
        t_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        t_lat = '{167, 68, 35, 233, 2};
        for (int i = 0; i < 5; i++) begin
            run_op(t_c1[i], t_b[i], t_x[i], t_p[i], lat, bok, e0);
            n_checks++;
            if (lat != t_lat[i]) begin
                n_fail++;
                $display("FAIL known%0d latency: got %0d expected %0d", i, lat, t_lat[i]);
            end
            n_checks++;
            if (k_o !== t_k[i] || r2_o !== t_r2[i] || err !== t_err[i]) begin
                n_fail++;
                $display("FAIL known%0d result: got k=%h r2=%h err=%b expected k=%h r2=%h err=%b",
                         i, k_o, r2_o, err, t_k[i], t_r2[i], t_err[i]);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_fail++;
                $display("FAIL known%0d busy: got bad busy profile, expected high until done only", i);
            end
        end
        repeat (5) tick();
        n_checks++;
        if (err !== 1'b1 || k_o !== 4'h0 || r2_o !== 4'h9 || done_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL err hold: got err=%b k=%h r2=%h done=%b expected 1 0 9 0",
                     err, k_o, r2_o, done_dec);
        end
        run_op(4'h3, 32'd5, 32'd0, 32'd23, lat, bok, e0);
        n_checks++;
        if (e0 !== 1'b0) begin
            n_fail++;
            $display("FAIL err clear on start: got %b expected 0", e0);
        end
        n_checks++;
        if (err !== 1'b0 || k_o !== 4'h1 || r2_o !== 4'h2 || lat != 35) begin
            n_fail++;
            $display("FAIL after err: got err=%b k=%h r2=%h lat=%0d expected 0 1 2 35",
                     err, k_o, r2_o, lat);
        end
    endtask

    task automatic test_random();
        logic [3:0]  rc;
        logic [31:0] rb;
        logic [31:0] rx;
        logic [31:0] rm;
        logic [31:0] mask;
        logic [3:0]  ek;
        logic        ee;
        int          bl;
        int          lat;
        logic        bok;
        logic        e0;
        for (int i = 0; i < 12; i++) begin
            rc = 4'($urandom);
            rb = $urandom;
            bl = $urandom_range(0, 32);
            mask = (bl == 32) ? 32'hFFFF_FFFF : ((32'd1 << bl) - 32'd1);
            rx = (bl == 0) ? 32'd0 : (($urandom & mask) | (32'd1 << (bl - 1)));
            case (i % 4)
                0:       rm = $urandom_range(2, 60);
                1:       rm = $urandom | 32'h8000_0000;
                2:       rm = $urandom;
                default: rm = $urandom_range(0, 3);
            endcase
            ee = (rm < 32'd2);
            ek = ee ? 4'h0 : ref_pow(rb, rx, rm)[3:0];
            run_op(rc, rb, rx, rm, lat, bok, e0);
            n_checks++;
            if (lat != ref_latency(rx, rm)) begin
                n_fail++;
                $display("FAIL rand%0d latency: got %0d expected %0d", i, lat, ref_latency(rx, rm));
            end
            n_checks++;
            if (k_o !== ek || r2_o !== (rc ^ ek) || err !== ee) begin
                n_fail++;
                $display("FAIL rand%0d result (b=%h x=%h p=%h): got k=%h r2=%h err=%b expected k=%h r2=%h err=%b",
                         i, rb, rx, rm, k_o, r2_o, err, ek, rc ^ ek, ee);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d busy: got bad busy profile, expected high until done only", i);
            end
        end
    endtask

    task automatic test_ignore_start();
        int         first_done = -1;
        int         n_done     = 0;
        logic [3:0] k_seen     = '0;
        logic [3:0] r2_seen    = '0;
        logic       err_seen   = 1'b0;
        c1 = 4'h5; pub_b = 32'd8; priv_x = 32'd6; p = 32'd23; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (n == 20) begin
                start = 1'b1; c1 = 4'hC; pub_b = 32'd3; priv_x = 32'd5; p = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (busy && done_dec) begin
                n_fail++;
                $display("FAIL overlap: got busy=1 with done_dec=1 at cycle %0d, expected never", n);
            end
            if (done_dec) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = n; k_seen = k_o; r2_seen = r2_o; err_seen = err;
                end
            end
        end
        n_checks++;
        if (n_done != 1 || first_done != 167) begin
            n_fail++;
            $display("FAIL ignore start: got %0d done pulses, first at %0d, expected 1 at 167",
                     n_done, first_done);
        end
        n_checks++;
        if (k_seen !== 4'hD || r2_seen !== 4'h8 || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore start values: got k=%h r2=%h err=%b expected D 8 0",
                     k_seen, r2_seen, err_seen);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done = 1'b0;
        c1 = 4'h5; pub_b = 32'd8; priv_x = 32'd6; p = 32'd23; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done_dec, err, k_o, r2_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset abort: got busy=%b done=%b err=%b k=%h r2=%h, expected all 0",
                     busy, done_dec, err, k_o, r2_o);
        end
        for (int n = 0; n < 300; n++) begin
            tick();
            if (done_dec) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset abort done: got a done_dec pulse, expected none");
        end
    endtask

    task automatic test_after_abort();
        int   lat;
        logic bok;
        logic e0;
        run_op(4'h5, 32'd8, 32'd6, 32'd23, lat, bok, e0);
        n_checks++;
        if (lat != 167 || k_o !== 4'hD || r2_o !== 4'h8 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after abort: got lat=%0d k=%h r2=%h err=%b expected 167 D 8 0",
                     lat, k_o, r2_o, err);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_after_abort();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
